// File: rtl/sample_capture_writer_if.sv
// Sample stream + RAM port A bundle for sample_capture_writer.
// master: sample source / observer side; slave: the writer.
interface sample_capture_writer_if #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_W    = 10
);
  logic [RAM_WIDTH-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [ADDR_W-1:0]    ram_addra;
  logic [RAM_WIDTH-1:0] ram_dina;
  logic                 ram_wea;
  logic                 ram_ena;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  ram_addra,
    input  ram_dina,
    input  ram_wea,
    input  ram_ena
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output ram_addra,
    output ram_dina,
    output ram_wea,
    output ram_ena
  );
endinterface

// File: rtl/sample_capture_writer.sv
// Captures a valid/ready sample stream into RAM port A at sequential
// addresses, with optional rising-level trigger and single-shot/wrap mode.
// Ports: clk, rst (sync, active-high), start/stop pulses, trig_en,
// trig_level, bus (stream in + RAM port A out), busy, done, wr_count.
module sample_capture_writer #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 1024,
  parameter int ADDR_W    = 10,
  parameter int WRAP_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 trig_en,
  input  logic [RAM_WIDTH-1:0] trig_level,
  sample_capture_writer_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      wr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W:0] FULL =
    (ADDR_W + 1)'(RAM_DEPTH);

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    addra_q;
  logic [RAM_WIDTH-1:0] dina_q;
  logic [RAM_WIDTH-1:0] prev_q;
  logic                 prev_vld_q;
  logic                 wea_q;
  logic                 rdy_q;
  logic                 busy_q;
  logic                 done_q;
  logic [ADDR_W:0]      cnt_q;

  logic                 accept;
  logic                 trig_hit;
  logic                 last_wr;
  logic [ADDR_W:0]      cnt_d;
  logic [ADDR_W-1:0]    addr_d;

  assign accept = bus.s_valid & rdy_q;

  // Rising crossing needs a previous sample in this arming.
  assign trig_hit = prev_vld_q
                  && (prev_q < trig_level)
                  && (bus.s_data >= trig_level);

  // Only single-shot mode stops at the top address.
  assign last_wr = (WRAP_MODE == 0) && (addr_q == LAST);

  assign cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
  assign addr_d = addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      addra_q    <= '0;
      dina_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wea_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wea_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          // start beats a simultaneous stop here
          if (start) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            prev_vld_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            rdy_q      <= 1'b1;
            state_q    <= trig_en ? S_ARMED : S_CAP;
          end
        end
        S_ARMED: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (accept) begin
            if (trig_hit) begin
              addra_q <= addr_q;
              dina_q  <= bus.s_data;
              wea_q   <= 1'b1;
              addr_q  <= addr_d;
              cnt_q   <= cnt_d;
              state_q <= S_CAP;
            end else begin
              prev_q     <= bus.s_data;
              prev_vld_q <= 1'b1;
            end
          end
        end
        S_CAP: begin
          if (accept) begin
            addra_q <= addr_q;
            dina_q  <= bus.s_data;
            wea_q   <= 1'b1;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
          end
          // ready drops on the same edge so nothing more is taken
          if (stop || (accept && last_wr)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready   = rdy_q;
  assign bus.ram_addra = addra_q;
  assign bus.ram_dina  = dina_q;
  assign bus.ram_wea   = wea_q;
  assign bus.ram_ena   = wea_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_count      = cnt_q;

endmodule
